// File: rtl/dbus_xbar_pkg.sv
// rtl/dbus_xbar_pkg.sv - shared types, default memory map and lane-alignment helpers for the data-bus crossbar
package dbus_xbar_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic [31:0] DMEM_BASE  = 32'h0000_0000;
    localparam logic [31:0] DMEM_MASK  = 32'hFFE0_0000;
    localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
    localparam logic [31:0] CLINT_MASK = 32'hFFFF_0000;
    localparam logic [31:0] PLIC_BASE  = 32'h0C00_0000;
    localparam logic [31:0] PLIC_MASK  = 32'hFC00_0000;
    localparam logic [31:0] UART0_BASE = 32'h1000_0000;
    localparam logic [31:0] UART1_BASE = 32'h1000_1000;
    localparam logic [31:0] SPI0_BASE  = 32'h1000_2000;
    localparam logic [31:0] SPI1_BASE  = 32'h1000_3000;
    localparam logic [31:0] GPIOA_BASE = 32'h1001_0000;
    localparam logic [31:0] GPIOB_BASE = 32'h1001_1000;
    localparam logic [31:0] GPIOC_BASE = 32'h1001_2000;
    localparam logic [31:0] GPSW_BASE  = 32'h1002_0000;
    localparam logic [31:0] GPLED_BASE = 32'h1002_1000;
    localparam logic [31:0] PERIPH_MASK = 32'hFFFF_F000;

    // Eight-port default map, slave 0 in the least significant slot
    localparam logic [8*32-1:0] DEF_SLV_BASE = {
        GPIOA_BASE, SPI1_BASE, SPI0_BASE, UART1_BASE,
        UART0_BASE, PLIC_BASE, CLINT_BASE, DMEM_BASE
    };
    localparam logic [8*32-1:0] DEF_SLV_MASK = {
        PERIPH_MASK, PERIPH_MASK, PERIPH_MASK, PERIPH_MASK,
        PERIPH_MASK, PLIC_MASK, CLINT_MASK, DMEM_MASK
    };

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] wdata;
    } lane_t;

    function automatic logic access_legal(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    access_legal = 1'b1;
            SZ_H:    access_legal = ~off[0];
            SZ_W:    access_legal = (off == 2'b00);
            default: access_legal = 1'b0;
        endcase
    endfunction

    // Loads use the same byte enables as stores but never carry data
    function automatic lane_t lane_align(input logic [1:0] size, input logic [1:0] off,
                                         input logic we, input logic [31:0] wd);
        lane_t r;
        r.be    = 4'b0000;
        r.wdata = 32'h0;
        case (size)
            SZ_B: begin
                r.be    = 4'b0001 << off;
                r.wdata = {24'h0, wd[7:0]} << {off, 3'b000};
            end
            SZ_H: begin
                r.be    = off[1] ? 4'b1100 : 4'b0011;
                r.wdata = off[1] ? {wd[15:0], 16'h0} : {16'h0, wd[15:0]};
            end
            SZ_W: begin
                r.be    = 4'b1111;
                r.wdata = wd;
            end
            default: ;
        endcase
        if (!we) begin
            r.wdata = 32'h0;
        end
        return r;
    endfunction

endpackage

// File: rtl/dbus_addr_decode.sv
// rtl/dbus_addr_decode.sv - priority base/mask address decoder, one-hot select plus hit flag
module dbus_addr_decode #(
    parameter int                          NUM_SLV  = 8,
    parameter int                          ADDR_W   = 32,
    parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_BASE = '0,
    parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_MASK = '0
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic [NUM_SLV-1:0] sel,
    output logic               hit
);

    // Scan from the top so the lowest matching index is the last to overwrite
    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                sel    = '0;
                sel[i] = 1'b1;
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dbus_xbar_ctrl.sv
// rtl/dbus_xbar_ctrl.sv - one-outstanding LSU-to-peripheral crossbar with alignment checks and ack timeout
module dbus_xbar_ctrl
    import dbus_xbar_pkg::*;
#(
    parameter int                          NUM_SLV     = 8,
    parameter int                          ADDR_W      = 32,
    parameter int                          DATA_W      = 32,
    parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_BASE    = DEF_SLV_BASE,
    parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_MASK    = DEF_SLV_MASK,
    parameter int                          TIMEOUT_CYC = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic                        req_we_i,
    input  logic [1:0]                  req_size_i,
    input  logic [ADDR_W-1:0]           req_addr_i,
    input  logic [DATA_W-1:0]           req_wdata_i,
    output logic                        rsp_valid_o,
    output logic [DATA_W-1:0]           rsp_rdata_o,
    output logic                        rsp_err_o,
    output logic [NUM_SLV-1:0]          slv_sel_o,
    output logic [ADDR_W-1:0]           slv_addr_o,
    output logic                        slv_we_o,
    output logic [3:0]                  slv_be_o,
    output logic [DATA_W-1:0]           slv_wdata_o,
    input  logic [NUM_SLV-1:0]          slv_ack_i,
    input  logic [NUM_SLV*DATA_W-1:0]   slv_rdata_i
);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_ACCESS = ST_ACCESS;
    localparam logic [1:0] S_RESP   = ST_RESP;

    localparam int         TW       = $clog2(TIMEOUT_CYC + 2);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    logic [1:0]          state;
    logic [NUM_SLV-1:0]  sel_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [3:0]          be_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic [TW-1:0]       tmo_cnt;

    logic [NUM_SLV-1:0]  dec_sel;
    logic                dec_hit;
    logic                acc_ok;
    lane_t               lane;
    logic [DATA_W-1:0]   ack_rdata;
    logic                ack_hit;
    logic                tmo_expire;

    dbus_addr_decode #(
        .NUM_SLV  (NUM_SLV),
        .ADDR_W   (ADDR_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decode (
        .addr (req_addr_i),
        .sel  (dec_sel),
        .hit  (dec_hit)
    );

    assign acc_ok = dec_hit & access_legal(req_size_i, req_addr_i[1:0]);
    assign lane   = lane_align(req_size_i, req_addr_i[1:0], req_we_i, req_wdata_i);

    // Select is one-hot, so an OR of the gated lanes is the selected slave's word
    always_comb begin
        ack_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_q[i]) begin
                ack_rdata = ack_rdata | slv_rdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ack_hit    = |(slv_ack_i & sel_q);
    assign tmo_expire = (TIMEOUT_CYC != 0) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            sel_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        addr_q  <= req_addr_i;
                        tmo_cnt <= '0;
                        err_q   <= ~acc_ok;
                        if (acc_ok) begin
                            sel_q   <= dec_sel;
                            we_q    <= req_we_i;
                            be_q    <= lane.be;
                            wdata_q <= lane.wdata;
                            state   <= S_ACCESS;
                        end else begin
                            we_q    <= 1'b0;
                            be_q    <= 4'b0000;
                            wdata_q <= '0;
                            rdata_q <= '0;
                            state   <= S_RESP;
                        end
                    end
                end
                S_ACCESS: begin
                    // An ack arriving in the expiry cycle still completes normally
                    if (ack_hit) begin
                        sel_q   <= '0;
                        rdata_q <= we_q ? '0 : ack_rdata;
                        err_q   <= 1'b0;
                        state   <= S_RESP;
                    end else if (tmo_expire) begin
                        sel_q   <= '0;
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state   <= S_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = (state == S_IDLE);
    assign rsp_valid_o = (state == S_RESP);
    assign rsp_err_o   = err_q & (state == S_RESP);
    assign rsp_rdata_o = rdata_q;
    assign slv_sel_o   = sel_q;
    assign slv_addr_o  = addr_q;
    assign slv_we_o    = we_q;
    assign slv_be_o    = be_q;
    assign slv_wdata_o = wdata_q;

endmodule

// File: doc/dbus_xbar_ctrl.md
Name: dbus_xbar_ctrl

Overview:
Parametrised successor to the fixed-map data-bus address decoder. Sits between the LSU and N data-bus peripherals (DMEM, UART, CLINT, PLIC, SPI, GPIO…), driven by a base/mask address table. Adds a registered request/ack handshake with a one-outstanding transaction FSM, byte-lane alignment for SB/SH/SW, decode-error and misalignment responses, and a per-access timeout so a dead peripheral cannot hang the core.

Parameters:
NUM_SLV, 8, number of peripheral ports (1..16)
ADDR_W, 32, bus address width
DATA_W, 32, data width; fixed at 32 in this generation
SLV_BASE, packed NUM_SLV*ADDR_W, per-slave base address; slave i spans addresses where (addr & SLV_MASK[i]) == SLV_BASE[i]
SLV_MASK, packed NUM_SLV*ADDR_W, per-slave compare mask
TIMEOUT_CYC, 255, max cycles waiting for ack before error; 0 disables the timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid_i  in  1  LSU request valid
req_ready_o  out  1  controller can accept a request
req_we_i  in  1  1 = store, 0 = load
req_size_i  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
req_addr_i  in  ADDR_W  byte address
req_wdata_i  in  DATA_W  store data, LSB-aligned
rsp_valid_o  out  1  one-cycle response strobe
rsp_rdata_o  out  DATA_W  raw 32-bit word from the slave; load extraction stays in the LSU
rsp_err_o  out  1  decode error, misalignment or timeout
slv_sel_o  out  NUM_SLV  one-hot slave select
slv_addr_o  out  ADDR_W  registered address
slv_we_o  out  1  registered write enable
slv_be_o  out  4  byte enables
slv_wdata_o  out  DATA_W  lane-aligned store data
slv_ack_i  in  NUM_SLV  per-slave completion strobe
slv_rdata_i  in  NUM_SLV*DATA_W  per-slave read data; slave i occupies bits [i*32 +: 32]

Behaviour:
- Reset (rst = 1 at a clk edge): state IDLE. req_ready_o = 1. rsp_valid_o, rsp_err_o, slv_sel_o, slv_we_o and slv_be_o are 0. slv_addr_o, slv_wdata_o, rsp_rdata_o and the timeout counter are 0.
- Reset mid-transaction aborts the access immediately. No response is issued, and a late ack is ignored.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready_o = 1. On req_valid_i, capture the request and decode it.
  - Legal and mapped: go to ACCESS.
  - Otherwise: go to RESP with err = 1.
- Decode: slave i matches if (addr & MASK[i]) == BASE[i]. On overlapping matches, the lowest index wins. No match is a decode error.
- Alignment checks:
  - half with addr[0] = 1 is an error.
  - word with addr[1:0] != 0 is an error.
  - size 3 is an error.
  - A misaligned or illegal request never asserts slv_sel_o.
- Lane alignment and byte enables:
  - byte: be = 0001 << addr[1:0]; wdata[7:0] is replicated to the selected lane and other lanes are 0.
  - half: be = 0011 or 1100; data goes to [15:0] or [31:16].
  - word: be = 1111.
  - Loads drive be from the same rule, wdata = 0.
- ACCESS: slv_sel_o is one-hot and address, we, be and wdata are held stable from the cycle after acceptance until ack. req_ready_o = 0.
  - On slv_ack_i[sel]: capture slv_rdata_i[sel] (stores return 0), drop select and go to RESP with err = 0.
  - Acks from unselected slaves are ignored.
- Timeout: the counter increments each ACCESS cycle. When it reaches TIMEOUT_CYC without ack, drop select and go to RESP with err = 1 and rdata = 0. If ack and expiry occur in the same cycle, the ack wins.
- RESP: rsp_valid_o = 1 for exactly one cycle, then IDLE. req_ready_o = 0 in RESP, so back-to-back requests are accepted every 3 cycles minimum.
- Latency:
  - Mapped slave acking in the first ACCESS cycle: accept at T, select at T+1, rsp_valid at T+2.
  - Errors: rsp_valid at T+1.
- The outputs hold no combinational path from req_*_i, because all slave-side signals are registered.

Decomposition:
- Package dbus_xbar_pkg holds:
  - the size enum (SZ_B, SZ_H, SZ_W);
  - the FSM state enum;
  - the default memory map constants (DMEM, CLINT, PLIC, UART0/1, SPI0/1, GPIOA/B/C, GPSW, GPLED base and mask);
  - a function computing byte enables and aligned data.
- One sub-module, dbus_addr_decode: combinational priority base/mask decoder producing a one-hot select and a hit flag, reused by the instruction-bus side.

Test Plan:
1. Word load at 0x0000_0100 (slave 0 = DMEM, base 0x0, mask 0xFFE0_0000), ack after 3 cycles with rdata 0xDEADBEEF → slv_sel_o = 0x01 held 3 cycles; rsp_valid 1 cycle, rsp_rdata 0xDEADBEEF, rsp_err 0.
2. Byte store 0xA5 to addr ending 2'b11 → slv_be_o 4'b1000, slv_wdata_o 0xA500_0000, slv_we_o 1; the remaining lanes of slv_wdata_o are 0.
3. Store to unmapped 0xF000_0000 → no slv_sel_o asserted; rsp_valid and rsp_err at T+1; req_ready returns 1 at T+2.
4. Half load at odd address 0x…01 → rsp_err 1, no select; size 3 → same.
5. Selected slave never acks, TIMEOUT_CYC = 8 → select dropped after 8 ACCESS cycles, rsp_err 1, rdata 0. Variant with ack in the expiry cycle → err 0, data returned.
6. Mid-ACCESS rst pulse, then a late ack → outputs at reset values, no rsp_valid; next request proceeds normally. Also: an ack from an unselected slave during ACCESS is ignored.
